// File: rtl/gbt_pkg.sv
// ============================================================================
// Module      : gbt_pkg
// Description : Shared widths, frame headers and framer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gbt_pkg;

    localparam int GBT_WORD_W    = 16;
    localparam int GBT_SLOTS     = 5;
    localparam int GBT_PAYLOAD_W = GBT_WORD_W * GBT_SLOTS;

    localparam logic [3:0] HDR_DATA = 4'b0101;
    localparam logic [3:0] HDR_IDLE = 4'b0110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } gbt_state_e;

endpackage

`default_nettype wire

// File: rtl/gbt_tx_framer.sv
// ============================================================================
// Module      : gbt_tx_framer
// Description : Packs 16-bit upstream words into 5-slot GBT frames, padding
//               and flushing on packet end, idle timeout or enable drop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gbt_tx_framer #(
    parameter logic [15:0] PAD_WORD = 16'hA5A5,
    parameter int          TIMEOUT  = 16,
    parameter logic [3:0]  HDR_DATA = gbt_pkg::HDR_DATA,
    parameter logic [3:0]  HDR_IDLE = gbt_pkg::HDR_IDLE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_din,
    input  logic        i_din_vld,
    input  logic        i_din_last,
    output logic        o_din_rdy,
    output logic [3:0]  o_tx_hdr,
    output logic [79:0] o_tx_data,
    output logic        o_tx_vld,
    output logic        o_tx_eop,
    output logic [15:0] o_frm_cnt
);

    import gbt_pkg::*;

    localparam logic [7:0]  c_TIMEOUT   = 8'(TIMEOUT);
    localparam logic [2:0]  c_LAST_SLOT = 3'(GBT_SLOTS - 1);
    localparam logic [79:0] c_IDLE_DATA = {GBT_SLOTS{PAD_WORD}};

    gbt_state_e  r_state;
    gbt_state_e  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [15:0] r_slot [GBT_SLOTS];
    logic [7:0]  r_timer;
    logic        w_xfer;
    logic        w_emit;
    logic        w_eop;
    logic [79:0] w_frame;

    logic [3:0]  r_tx_hdr;
    logic [79:0] r_tx_data;
    logic        r_tx_vld;
    logic        r_tx_eop;
    logic [15:0] r_frm_cnt;

    assign o_din_rdy = i_en && !rst;
    assign w_xfer    = i_din_vld && o_din_rdy;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_emit      = 1'b0;
        w_eop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (i_din_last) begin
                        w_emit = 1'b1;
                        w_eop  = 1'b1;
                    end else begin
                        w_state_nxt = ST_FILL;
                        w_cnt_nxt   = 3'd1;
                    end
                end
            end
            ST_FILL: begin
                if (w_xfer) begin
                    if (i_din_last || (r_cnt == c_LAST_SLOT)) begin
                        w_emit      = 1'b1;
                        w_eop       = i_din_last;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end else if (!i_en || (r_timer == c_TIMEOUT)) begin
                    // Flush without end-of-packet: enable dropped or stream went quiet.
                    w_emit      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Held slots below the count, the word arriving now at the count, pads beyond.
    always_comb begin
        w_frame = c_IDLE_DATA;
        for (int i = 0; i < GBT_SLOTS; i++) begin
            if (i < int'(r_cnt)) begin
                w_frame[(GBT_SLOTS-1-i)*GBT_WORD_W +: GBT_WORD_W] = r_slot[i];
            end else if ((i == int'(r_cnt)) && w_xfer) begin
                w_frame[(GBT_SLOTS-1-i)*GBT_WORD_W +: GBT_WORD_W] = i_din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_timer <= 8'd0;
            for (int i = 0; i < GBT_SLOTS; i++) begin
                r_slot[i] <= 16'd0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_xfer) begin
                r_slot[r_cnt] <= i_din;
            end
            if (w_xfer || (w_state_nxt == ST_IDLE)) begin
                r_timer <= 8'd0;
            end else begin
                r_timer <= r_timer + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_vld  <= 1'b0;
            r_tx_eop  <= 1'b0;
            r_tx_hdr  <= HDR_IDLE;
            r_tx_data <= c_IDLE_DATA;
            r_frm_cnt <= 16'd0;
        end else begin
            r_tx_vld  <= w_emit;
            r_tx_eop  <= w_eop;
            r_tx_hdr  <= w_emit ? HDR_DATA : HDR_IDLE;
            r_tx_data <= w_emit ? w_frame : c_IDLE_DATA;
            r_frm_cnt <= r_frm_cnt + 16'(r_tx_vld);
        end
    end

    assign o_tx_hdr  = r_tx_hdr;
    assign o_tx_data = r_tx_data;
    assign o_tx_vld  = r_tx_vld;
    assign o_tx_eop  = r_tx_eop;
    assign o_frm_cnt = r_frm_cnt;

endmodule

`default_nettype wire

// File: tb/tb_gbt_tx_framer.sv
// ============================================================================
// Module      : tb_gbt_tx_framer
// Description : Directed scoreboard bench for gbt_tx_framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_gbt_tx_framer;

    localparam logic [15:0] PAD       = 16'hA5A5;
    localparam logic [79:0] IDLE_DATA = {5{PAD}};
    localparam logic [3:0]  H_DATA    = 4'b0101;
    localparam logic [3:0]  H_IDLE    = 4'b0110;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [15:0] din = 16'd0;
    logic        din_vld = 1'b0;
    logic        din_last = 1'b0;
    logic        din_rdy;
    logic [3:0]  tx_hdr;
    logic [79:0] tx_data;
    logic        tx_vld;
    logic        tx_eop;
    logic [15:0] frm_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int prev_frame_cyc = 0;
    int frame_gap = 0;

    logic [79:0] q_data [$];
    logic        q_eop  [$];

    gbt_tx_framer #(
        .PAD_WORD (16'hA5A5),
        .TIMEOUT  (16),
        .HDR_DATA (4'b0101),
        .HDR_IDLE (4'b0110)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_din      (din),
        .i_din_vld  (din_vld),
        .i_din_last (din_last),
        .o_din_rdy  (din_rdy),
        .o_tx_hdr   (tx_hdr),
        .o_tx_data  (tx_data),
        .o_tx_vld   (tx_vld),
        .o_tx_eop   (tx_eop),
        .o_frm_cnt  (frm_cnt)
    );

    always #12.5 clk = ~clk;

    // Monitor: every cycle either a queued frame or idle filler must be present.
    always @(posedge clk) begin
        logic [79:0] exp_d;
        logic        exp_e;
        #1;
        cyc++;
        n_vec++;
        if (tx_vld) begin
            frame_gap      = cyc - prev_frame_cyc;
            prev_frame_cyc = cyc;
            if (q_data.size() == 0) begin
                n_err++;
                $display("FAIL spurious_frame: got hdr=%h data=%h eop=%b, required no frame",
                         tx_hdr, tx_data, tx_eop);
            end else begin
                exp_d = q_data.pop_front();
                exp_e = q_eop.pop_front();
                if (tx_hdr !== H_DATA || tx_data !== exp_d || tx_eop !== exp_e) begin
                    n_err++;
                    $display("FAIL frame: got hdr=%h data=%h eop=%b, required hdr=%h data=%h eop=%b",
                             tx_hdr, tx_data, tx_eop, H_DATA, exp_d, exp_e);
                end
            end
        end else if (tx_hdr !== H_IDLE || tx_data !== IDLE_DATA || tx_eop !== 1'b0) begin
            n_err++;
            $display("FAIL idle_out: got hdr=%h data=%h eop=%b, required hdr=%h data=%h eop=0",
                     tx_hdr, tx_data, tx_eop, H_IDLE, IDLE_DATA);
        end
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [79:0] d, input logic e);
        q_data.push_back(d);
        q_eop.push_back(e);
    endtask

    task automatic send(input logic [15:0] w, input logic last);
        din      = w;
        din_vld  = 1'b1;
        din_last = last;
        @(posedge clk);
        #2;
        din_vld  = 1'b0;
        din_last = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(posedge clk); #2;
        chk("rdy_in_reset", 80'(din_rdy), 80'd0);
        chk("frm_cnt_reset", 80'(frm_cnt), 80'd0);
        chk("vld_reset", 80'(tx_vld), 80'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rdy_after_reset", 80'(din_rdy), 80'd1);
        idle(1);

        // Ten back-to-back words: two full frames five cycles apart
        push(80'h0001_0002_0003_0004_0005, 1'b0);
        push(80'h0006_0007_0008_0009_000A, 1'b0);
        for (int i = 1; i <= 10; i++) begin
            send(16'(i), 1'b0);
        end
        idle(2);
        chk("stream_gap", 80'(frame_gap), 80'd5);
        chk("stream_frm_cnt", 80'(frm_cnt), 80'd2);

        // Two-word packet closed by LAST
        push(80'h1111_2222_A5A5_A5A5_A5A5, 1'b1);
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        chk("last_latency_vld", 80'(tx_vld), 80'd1);
        idle(2);

        // Three words then silence: flush 17 cycles after the third transfer
        push(80'h3001_3002_3003_A5A5_A5A5, 1'b0);
        send(16'h3001, 1'b0);
        send(16'h3002, 1'b0);
        send(16'h3003, 1'b0);
        idle(16);
        chk("timeout_not_early", 80'(tx_vld), 80'd0);
        idle(1);
        chk("timeout_flush_vld", 80'(tx_vld), 80'd1);
        idle(2);

        // Enable drop mid-frame flushes a padded frame next cycle
        push(80'h4001_4002_A5A5_A5A5_A5A5, 1'b0);
        send(16'h4001, 1'b0);
        send(16'h4002, 1'b0);
        en = 1'b0;
        #1;
        chk("rdy_en_low", 80'(din_rdy), 80'd0);
        idle(1);
        chk("en_fall_vld", 80'(tx_vld), 80'd1);
        din_vld = 1'b1;
        idle(3);
        din_vld = 1'b0;
        en = 1'b1;
        idle(1);

        // Fifth word carrying LAST: one frame, no trailing empty frame
        push(80'h6001_6002_6003_6004_6005, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            send(16'h6000 + 16'(i), (i == 5));
        end
        idle(3);

        // Single-word packet from IDLE
        push(80'h7001_A5A5_A5A5_A5A5_A5A5, 1'b1);
        send(16'h7001, 1'b1);
        idle(2);
        chk("frm_cnt_before_rst", 80'(frm_cnt), 80'd7);

        // Partial frame discarded by reset
        for (int i = 1; i <= 4; i++) begin
            send(16'h5000 + 16'(i), 1'b0);
        end
        rst = 1'b1;
        #1;
        chk("rdy_rst_high", 80'(din_rdy), 80'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        push(80'h8001_8002_8003_8004_8005, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            send(16'h8000 + 16'(i), 1'b0);
        end
        idle(2);
        chk("frm_cnt_after_rst", 80'(frm_cnt), 80'd1);

        // Drive the frame counter to its top value, then wrap
        for (int n = 0; n < 65534; n++) begin
            push({16'(n), PAD, PAD, PAD, PAD}, 1'b1);
            send(16'(n), 1'b1);
        end
        idle(2);
        chk("frm_cnt_max", 80'(frm_cnt), 80'hFFFF);
        push({16'hBEEF, PAD, PAD, PAD, PAD}, 1'b1);
        send(16'hBEEF, 1'b1);
        idle(2);
        chk("frm_cnt_wrap", 80'(frm_cnt), 80'd0);

        idle(3);
        chk("queue_drain", 80'(q_data.size()), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gbt_tx_framer.md
GBT_TX_FRAMER -- requirements
Module: gbt_tx_framer

Interface
REQ-001 Parameter PAD_WORD, default 16'hA5A5: filler for unused frame slots and idle payload.
REQ-002 Parameter TIMEOUT, default 16: idle cycles in FILL before a partial frame is flushed; legal range 2..255.
REQ-003 Parameter HDR_DATA, default 4'b0101: header of a data frame.
REQ-004 Parameter HDR_IDLE, default 4'b0110: header of an idle frame.
REQ-005 CLK  in  1  40 MHz frame clock; all logic on rising edge.
REQ-006 RST  in  1  synchronous, active-high reset.
REQ-007 EN  in  1  framing enable.
REQ-008 DIN  in  16  upstream data word.
REQ-009 DIN_VLD  in  1  DIN valid.
REQ-010 DIN_LAST  in  1  DIN is the final word of a packet; qualified by DIN_VLD.
REQ-011 DIN_RDY  out  1  framer accepts DIN this cycle.
REQ-012 TX_HDR  out  4  frame header to GBT transmitter.
REQ-013 TX_DATA  out  80  frame payload; slot0 in [79:64] through slot4 in [15:0].
REQ-014 TX_VLD  out  1  data frame present; drives the GBT_TXVD output path.
REQ-015 TX_EOP  out  1  current data frame closes a packet.
REQ-016 FRM_CNT  out  16  count of data frames emitted.

Function
REQ-017 A word transfers when DIN_VLD and DIN_RDY are both high on a rising edge.
REQ-018 DIN_RDY is high when EN is high and RST is low, otherwise low; there is no output backpressure.
REQ-019 States: IDLE (slot count 0) and FILL (slot count 1..4); the slot counter is 3 bits.
REQ-020 IDLE -> FILL on a transfer without DIN_LAST; the word lands in slot0.
REQ-021 In FILL, each transfer writes slot[count] and increments count.
REQ-022 A frame is emitted when any of the following occurs:
- the 5th word transfers;
- a transfer carries DIN_LAST;
- TIMEOUT consecutive cycles pass in FILL without a transfer;
- EN falls while in FILL.
REQ-023 Emission: on the next cycle, TX_VLD=1, TX_HDR=HDR_DATA, TX_DATA = filled slots with every unfilled slot set to PAD_WORD; the state returns to IDLE with count 0.
REQ-024 TX_EOP=1 on an emitted frame only when the emission was caused by DIN_LAST; it is 0 for timeout and EN-fall flushes.
REQ-025 A transfer in IDLE carrying DIN_LAST emits a one-word frame (slot0 plus 4 pads) with TX_EOP=1.
REQ-026 A 5th word that also carries DIN_LAST yields one frame with TX_EOP=1, with no extra empty frame.
REQ-027 A transfer in the same cycle as an emission starts a new frame in slot0; the framer sustains 5 words per 5 cycles with no bubble.
REQ-028 In any cycle without emission: TX_VLD=0, TX_EOP=0, TX_HDR=HDR_IDLE, TX_DATA={5{PAD_WORD}}.
REQ-029 Timeout counter:
- reloads on every transfer and on entry to FILL;
- counts only in FILL;
- is inactive in IDLE.
REQ-030 FRM_CNT increments on every cycle in which TX_VLD=1 and wraps from 16'hFFFF to 0.
REQ-031 All outputs are registered; latency from the last contributing transfer to TX_VLD is exactly 1 cycle.

Reset
REQ-032 When RST=1 at an edge, the next state is as follows:
- state=IDLE, count=0, slots cleared, timer cleared;
- TX_VLD=0, TX_EOP=0, TX_HDR=HDR_IDLE, TX_DATA={5{PAD_WORD}}, FRM_CNT=0;
- DIN_RDY=0 while RST is high.
REQ-033 A partial frame held when RST asserts is discarded and never emitted.

Structure
REQ-034 The shared package gbt_pkg holds:
- GBT_WORD_W=16, GBT_SLOTS=5, GBT_PAYLOAD_W=80;
- header constants HDR_DATA/HDR_IDLE;
- the state enumeration.
REQ-035 gbt_tx_framer is a single module with no sub-module; the timeout counter is inline.

Verification
REQ-036 Stream 10 consecutive words 0x0001..0x000A, no LAST -> two frames on consecutive-5 spacing with payloads 0001..0005 and 0006..000A, TX_EOP=0, FRM_CNT=2.
REQ-037 Send 0x1111, 0x2222 (LAST) -> one cycle later: TX_DATA=1111_2222_A5A5_A5A5_A5A5, TX_HDR=0101, TX_EOP=1.
REQ-038 Send 3 words, then hold DIN_VLD low -> frame emitted 17 cycles after the 3rd transfer (TIMEOUT=16) with 2 pad slots, TX_EOP=0.
REQ-039 Send 2 words, drop EN -> padded frame next cycle, DIN_RDY=0 while EN is low, state IDLE.
REQ-040 Send 4 words, assert RST for 1 cycle, then send 5 new words -> only the 5-word frame appears; FRM_CNT=1.
REQ-041 Preload FRM_CNT to 16'hFFFF by emitting 65535 frames, then emit 1 more -> FRM_CNT=0.
